// File: rtl/matmul_sched_if.sv
// matmul_sched_if: control and address bundle between the matmul job controller
// and the dot-product sequencer.
//   master : drives start, cfg_rows, cfg_cols, hold; observes status and strobes
//   slave  : the sequencer; drives busy, done, issue_*, wr_*
// Ports (signals):
//   start        begin a job (sampled by the sequencer only when idle)
//   cfg_rows     M of the job, ROW_W+1 bits
//   cfg_cols     N of the job, COL_W+1 bits
//   hold         suppress issuing this cycle
//   busy, done   job status / one-cycle completion pulse
//   issue_*      operand select towards the dot unit
//   wr_*         result-memory write strobe and address
interface matmul_sched_if #(
    parameter int unsigned ROW_W = 2,
    parameter int unsigned COL_W = 2
) ();
    logic             start;
    logic [ROW_W:0]   cfg_rows;
    logic [COL_W:0]   cfg_cols;
    logic             hold;
    logic             busy;
    logic             done;
    logic             issue_valid;
    logic [ROW_W-1:0] issue_row;
    logic [COL_W-1:0] issue_col;
    logic             wr_en;
    logic [ROW_W-1:0] wr_row;
    logic [COL_W-1:0] wr_col;

    modport master (
        output start, cfg_rows, cfg_cols, hold,
        input  busy, done, issue_valid, issue_row, issue_col, wr_en, wr_row, wr_col
    );

    modport slave (
        input  start, cfg_rows, cfg_cols, hold,
        output busy, done, issue_valid, issue_row, issue_col, wr_en, wr_row, wr_col
    );
endinterface

// File: rtl/matmul_sched.sv
// matmul_sched: sequencer for the pipelined dot-product datapath. Walks every
// (row, col) of an M x N result in row-major order, issuing one operand select
// per non-held cycle, and tracks the dot unit's fixed latency with a
// {valid,row,col} delay line whose tail drives the result-memory write strobe.
// Ports:
//   clk   system clock (posedge)
//   rst   synchronous active-high reset; aborts any job in progress
//   bus   matmul_sched_if.slave: start/cfg/hold in; busy/done/issue_*/wr_* out
module matmul_sched #(
    parameter int unsigned MAX_ROWS    = 4,
    parameter int unsigned MAX_COLS    = 4,
    parameter int unsigned DOT_LATENCY = 3,
    parameter int unsigned ROW_W       = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1,
    parameter int unsigned COL_W       = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    matmul_sched_if.slave bus
);
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam int unsigned RW1 = ROW_W + 1;
    localparam int unsigned CW1 = COL_W + 1;
    localparam logic [ROW_W:0] MaxRows = RW1'(MAX_ROWS);
    localparam logic [COL_W:0] MaxCols = CW1'(MAX_COLS);

    logic [1:0]       state_q, state_d;
    logic [ROW_W:0]   rows_q, rows_d;
    logic [COL_W:0]   cols_q, cols_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;

    logic [DOT_LATENCY-1:0] dl_valid_q;
    logic [ROW_W-1:0]       dl_row_q [DOT_LATENCY];
    logic [COL_W-1:0]       dl_col_q [DOT_LATENCY];

    logic issue_valid;
    logic last_row;
    logic last_col;
    logic cfg_bad;
    logic in_flight;

    assign issue_valid = (state_q == StIssue) && !bus.hold;
    assign last_row    = ({1'b0, row_q} + RW1'(1)) == rows_q;
    assign last_col    = ({1'b0, col_q} + CW1'(1)) == cols_q;
    assign cfg_bad     = (bus.cfg_rows == '0) || (bus.cfg_cols == '0) ||
                         (bus.cfg_rows > MaxRows) || (bus.cfg_cols > MaxCols);

    // Results still travelling towards the tail. The tail entry itself is being
    // written this cycle, so DONE can follow on the very next cycle.
    always_comb begin
        in_flight = 1'b0;
        for (int i = 0; i + 1 < int'(DOT_LATENCY); i++) begin
            in_flight = in_flight | dl_valid_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        rows_d  = rows_q;
        cols_d  = cols_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    rows_d  = bus.cfg_rows;
                    cols_d  = bus.cfg_cols;
                    row_d   = '0;
                    col_d   = '0;
                    // An empty/oversized job passes through DRAIN (line is empty)
                    // so busy is still seen for one cycle before done.
                    state_d = cfg_bad ? StDrain : StIssue;
                end
            end
            StIssue: begin
                if (!bus.hold) begin
                    if (last_col && last_row) begin
                        state_d = StDrain;  // counters freeze at (M-1, N-1)
                    end else if (last_col) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            StDrain: begin
                if (!in_flight) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rows_q  <= '0;
            cols_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Delay line shifts every cycle, independent of state and hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            dl_valid_q <= '0;
            for (int i = 0; i < int'(DOT_LATENCY); i++) begin
                dl_row_q[i] <= '0;
                dl_col_q[i] <= '0;
            end
        end else begin
            for (int i = int'(DOT_LATENCY) - 1; i > 0; i--) begin
                dl_valid_q[i] <= dl_valid_q[i-1];
                dl_row_q[i]   <= dl_row_q[i-1];
                dl_col_q[i]   <= dl_col_q[i-1];
            end
            dl_valid_q[0] <= issue_valid;
            dl_row_q[0]   <= row_q;
            dl_col_q[0]   <= col_q;
        end
    end

    assign bus.busy        = (state_q == StIssue) || (state_q == StDrain);
    assign bus.done        = (state_q == StDone);
    assign bus.issue_valid = issue_valid;
    assign bus.issue_row   = row_q;
    assign bus.issue_col   = col_q;
    assign bus.wr_en       = dl_valid_q[DOT_LATENCY-1];
    assign bus.wr_row      = dl_row_q[DOT_LATENCY-1];
    assign bus.wr_col      = dl_col_q[DOT_LATENCY-1];
endmodule

// File: tb/tb_matmul_sched.sv
// tb_matmul_sched: drives two sequencers (dot latency 3 and 1) with identical
// stimulus and checks every output, every cycle, against a job timeline derived
// from the hold pattern: k-th issue at the k-th non-held cycle after start,
// write L cycles later, done one cycle after the last write.
module tb_matmul_sched;
    localparam int LAT0 = 3;
    localparam int LAT1 = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matmul_sched_if #(.ROW_W(2), .COL_W(2)) bus0 ();
    matmul_sched_if #(.ROW_W(2), .COL_W(2)) bus1 ();

    assign bus1.start    = bus0.start;
    assign bus1.cfg_rows = bus0.cfg_rows;
    assign bus1.cfg_cols = bus0.cfg_cols;
    assign bus1.hold     = bus0.hold;

    matmul_sched #(.MAX_ROWS(4), .MAX_COLS(4), .DOT_LATENCY(LAT0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    matmul_sched #(.MAX_ROWS(4), .MAX_COLS(4), .DOT_LATENCY(LAT1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int errors = 0;
    int checks = 0;
    bit hold_plan [128];

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input int d, input int c, input bit e_busy, input bit e_done,
                           input bit e_iv, input int e_ir, input int e_ic, input bit e_wr,
                           input int e_wrr, input int e_wrc, input bit addr_i, input bit addr_w);
        logic       busy, done, iv, wr;
        logic [1:0] ir, ic, wrr, wrc;
        string      p;
        if (d == 0) begin
            busy = bus0.busy; done = bus0.done; iv = bus0.issue_valid; wr = bus0.wr_en;
            ir = bus0.issue_row; ic = bus0.issue_col; wrr = bus0.wr_row; wrc = bus0.wr_col;
        end else begin
            busy = bus1.busy; done = bus1.done; iv = bus1.issue_valid; wr = bus1.wr_en;
            ir = bus1.issue_row; ic = bus1.issue_col; wrr = bus1.wr_row; wrc = bus1.wr_col;
        end
        p = $sformatf("dut%0d c%0d", d, c);
        chk({p, " busy"}, busy, e_busy);
        chk({p, " done"}, done, e_done);
        chk({p, " issue_valid"}, iv, e_iv);
        chk({p, " wr_en"}, wr, e_wr);
        if (addr_i) begin
            chk({p, " issue_row"}, ir, e_ir);
            chk({p, " issue_col"}, ic, e_ic);
        end
        if (addr_w) begin
            chk({p, " wr_row"}, wrr, e_wrr);
            chk({p, " wr_col"}, wrc, e_wrc);
        end
    endtask

    // mode 0: no hold; mode 1: random hold (none late, so every job completes)
    task automatic set_hold(input int mode);
        for (int c = 0; c < 128; c++) begin
            hold_plan[c] = (mode == 1 && c < 60) ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
    endtask

    // Cycle 0 presents start; abort_at >= 0 pulses rst during that cycle.
    task automatic run_job(input int rows, input int cols, input int abort_at, input bit spam);
        int  iss_cyc [16];
        int  done_c [2];
        int  n_iss, k, c_end, d_min, d_max;
        bit  ok, aborted, e_iv, e_wr;
        int  e_ir, e_ic, e_wrr, e_wrc;
        ok    = rows > 0 && cols > 0 && rows <= 4 && cols <= 4;
        n_iss = ok ? rows * cols : 0;
        k = 0;
        for (int c = 1; c < 128 && k < n_iss; c++) begin
            if (!hold_plan[c]) begin
                iss_cyc[k] = c;
                k++;
            end
        end
        for (int d = 0; d < 2; d++) begin
            done_c[d] = ok ? iss_cyc[n_iss-1] + lat_of(d) + 1 : 2;
        end
        d_min = (done_c[0] < done_c[1]) ? done_c[0] : done_c[1];
        d_max = (done_c[0] > done_c[1]) ? done_c[0] : done_c[1];
        c_end = (abort_at >= 0) ? abort_at + 6 : d_max;
        for (int c = 0; c <= c_end; c++) begin
            @(negedge clk);
            rst       = (c == abort_at);
            bus0.hold = hold_plan[c];
            if (c == 0) begin
                bus0.start    = 1'b1;
                bus0.cfg_rows = 3'(rows);
                bus0.cfg_cols = 3'(cols);
            end else begin
                bus0.start    = spam && c < d_min && ($urandom_range(0, 1) == 1);
                bus0.cfg_rows = 3'($urandom);
                bus0.cfg_cols = 3'($urandom);
            end
            #1;
            aborted = abort_at >= 0 && c > abort_at;
            for (int d = 0; d < 2; d++) begin
                e_iv = 1'b0; e_wr = 1'b0; e_ir = 0; e_ic = 0; e_wrr = 0; e_wrc = 0;
                for (int j = 0; j < n_iss; j++) begin
                    if (iss_cyc[j] == c) begin
                        e_iv = 1'b1; e_ir = j / cols; e_ic = j % cols;
                    end
                    if (iss_cyc[j] + lat_of(d) == c) begin
                        e_wr = 1'b1; e_wrr = j / cols; e_wrc = j % cols;
                    end
                end
                if (aborted) begin
                    chk_dut(d, c, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 1'b1);
                end else begin
                    chk_dut(d, c, c >= 1 && c < done_c[d], c == done_c[d],
                            e_iv, e_ir, e_ic, e_wr, e_wrr, e_wrc, e_iv, e_wr);
                end
            end
        end
        @(negedge clk);
        bus0.start = 1'b0;
        rst        = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus0.start    = 1'b0;
        bus0.hold     = 1'b0;
        bus0.cfg_rows = '0;
        bus0.cfg_cols = '0;
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk_dut(d, -1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 1'b1);
        end

        // 2x3, no hold
        set_hold(0);
        run_job(2, 3, -1, 1'b0);

        // 4x4 with two bubbles on issue cycles 2 and 5
        set_hold(0);
        hold_plan[2] = 1'b1;
        hold_plan[5] = 1'b1;
        run_job(4, 4, -1, 1'b0);

        // degenerate / oversized configurations
        set_hold(0);
        run_job(0, 3, -1, 1'b0);
        run_job(5, 3, -1, 1'b0);
        run_job(3, 0, -1, 1'b0);
        run_job(2, 5, -1, 1'b0);

        // start spam during the job, then a back-to-back job
        set_hold(1);
        run_job(3, 4, -1, 1'b1);
        set_hold(0);
        run_job(2, 2, -1, 1'b0);

        // reset two cycles after the first issue, then a full job
        set_hold(0);
        run_job(4, 4, 3, 1'b0);
        run_job(4, 4, -1, 1'b0);

        // single element
        run_job(1, 1, -1, 1'b0);

        // random jobs
        for (int n = 0; n < 20; n++) begin
            set_hold(1);
            run_job($urandom_range(0, 5), $urandom_range(0, 5), -1, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
